darkuart_rx: RTL and testbench
==============================

Name: darkuart_rx

Overview:
- UART receive front end for the darksocv SoC.
- Sits directly upstream of the core's UART register: it takes the raw UART_RXD pin, deserialises 8N1 frames (8 data bits, no parity, 1 stop bit) and buffers the bytes in a small FIFO.
- The SoC I/O decoder pops bytes through a single-cycle read strobe.
- It replaces the ad-hoc RX sampling in the SoC top and adds sticky overrun and framing-error status.

Parameters:
- BAUD_DIV, 868: XCLK cycles per UART bit (100 MHz / 115200). Must be ≥ 8.
- FIFO_DEPTH, 4: receive FIFO entries. Power of two, 2..16.
- LW, 3: width of RX_LEVEL, equal to log2(FIFO_DEPTH)+1.

Ports:
- XCLK  in  1  system clock.
- XRES  in  1  reset, synchronous, active-high.
- UART_RXD  in  1  asynchronous serial input, idle high.
- RX_RD  in  1  pop strobe, one XCLK cycle per byte.
- RX_CLR  in  1  clears the sticky error flags.
- RX_DATA  out  8  FIFO head byte; valid only while RX_VALID=1.
- RX_VALID  out  1  FIFO not empty.
- RX_LEVEL  out  LW  number of bytes held, 0..FIFO_DEPTH.
- RX_OVR  out  1  sticky: a byte was dropped because the FIFO was full.
- RX_FERR  out  1  sticky: a stop bit was sampled low.

Behaviour:
- Reset:
  - Synchronizer flops = 1; state = IDLE; bit counter and divider = 0.
  - FIFO empty; RX_VALID=0, RX_LEVEL=0, RX_DATA=0, RX_OVR=0, RX_FERR=0.
  - Asserting XRES mid-frame aborts the frame; a partially shifted byte is never pushed.
- Input synchronizer:
  - 2-flop synchronizer gives rxs. A third flop rxs_q is used for edge detection.
  - Start detect is rxs==0 && rxs_q==1. A line held low never retriggers.
- State machine:
  - IDLE: on start detect, div = BAUD_DIV/2 - 1, go to START.
  - START: when div==0, sample rxs.
    - If rxs==0: div = BAUD_DIV-1, bit index = 0, go to DATA.
    - If rxs==1 (glitch): return to IDLE with no flags set.
    - Otherwise div decrements each cycle.
  - DATA: when div==0, shift rxs in LSB first and reload div = BAUD_DIV-1. After bit 7, go to STOP (or PARITY, see Optional Feature).
  - STOP: when div==0, sample rxs.
    - rxs==1: push the byte into the FIFO.
    - rxs==0: set RX_FERR and discard the byte.
    - Either case: go to IDLE.
- FIFO:
  - Register-array FIFO with read and write pointers one bit wider than the address, so full and empty are distinguishable.
  - A pushed byte is visible on RX_DATA, with RX_VALID=1, on the cycle after the STOP sample cycle.
  - RX_DATA is the head entry, read combinationally from the array.
  - RX_RD with RX_VALID=1: pointer advances and RX_LEVEL decrements at the next edge.
  - RX_RD with RX_VALID=0: ignored, no state change.
  - Push while full with no pop in the same cycle: byte dropped, RX_OVR set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun, RX_LEVEL unchanged.
  - Push and pop in the same cycle while empty: push only (there was nothing to pop); RX_LEVEL becomes 1.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- Error flags:
  - RX_CLR clears RX_OVR and RX_FERR at the next edge.
  - If a set condition occurs in the same cycle as RX_CLR, set wins.
- Latency:
  - Start-edge detect lags the pin by 3 cycles (2 synchronizer stages plus the edge flop).
  - Each bit is sampled at its nominal centre ±1 cycle.

Optional Feature:
- Macro: DARKUART_RX_PARITY_EN.
- Defined:
  - Frame format is 8E1. A PARITY state is inserted between DATA and STOP, sampled at div==0.
  - Port RX_PERR (out, 1) is added: sticky, set when the XOR of the 8 data bits and the parity bit is 1, cleared by RX_CLR with the same set-wins rule.
  - A byte with a parity error is still pushed, provided its stop bit is good.
- Undefined: 8N1 framing, no PARITY state, no RX_PERR port.

Test Plan (all cases use BAUD_DIV=16, FIFO_DEPTH=4):
- Reset then send byte 0x55 → RX_VALID=1 with RX_DATA=0x55 exactly one cycle after the stop-sample cycle (stop bit sampled at bit centre); RX_LEVEL=1; one RX_RD pulse → RX_VALID=0, RX_LEVEL=0.
- Send 0xA3, 0x00, 0xFF, 0x7E, then 0x11 with no reads → RX_LEVEL=4, RX_OVR=1; pops return 0xA3, 0x00, 0xFF, 0x7E in order; 0x11 is lost.
- Send 0x3C with the stop bit forced low → RX_FERR=1, RX_LEVEL=0; RX_CLR pulse → RX_FERR=0.
- 5-cycle low glitch on UART_RXD → no push, no flags, FSM back in IDLE; a following 0x81 is received correctly.
- FIFO full with a push and RX_RD in the same cycle → RX_OVR stays 0, RX_LEVEL stays 4, the newest byte ends up at the tail.
- XRES asserted during bit 4 of a frame → all outputs return to reset values; the next complete frame 0x42 is received correctly. With DARKUART_RX_PARITY_EN defined, 0x42 sent with parity bit 1 (odd overall) → RX_PERR=1 and the byte is pushed.

Source files
------------

// File: rtl/darkuart_rx_if.sv
// darkuart_rx_if: register-side bus of the UART receiver.
// slave  = receiver (drives data/status), master = SoC I/O decoder.
// RX_PERR exists only when DARKUART_RX_PARITY_EN is defined.
interface darkuart_rx_if #(
    parameter int LW = 3
);
    logic          RX_RD;
    logic          RX_CLR;
    logic [7:0]    RX_DATA;
    logic          RX_VALID;
    logic [LW-1:0] RX_LEVEL;
    logic          RX_OVR;
    logic          RX_FERR;
`ifdef DARKUART_RX_PARITY_EN
    logic          RX_PERR;

    modport slave  (input  RX_RD, RX_CLR,
                    output RX_DATA, RX_VALID, RX_LEVEL, RX_OVR, RX_FERR, RX_PERR);
    modport master (output RX_RD, RX_CLR,
                    input  RX_DATA, RX_VALID, RX_LEVEL, RX_OVR, RX_FERR, RX_PERR);
`else
    modport slave  (input  RX_RD, RX_CLR,
                    output RX_DATA, RX_VALID, RX_LEVEL, RX_OVR, RX_FERR);
    modport master (output RX_RD, RX_CLR,
                    input  RX_DATA, RX_VALID, RX_LEVEL, RX_OVR, RX_FERR);
`endif
endinterface

// File: rtl/darkuart_rx.sv
// darkuart_rx: UART receive front end (8N1, or 8E1 with DARKUART_RX_PARITY_EN)
// with a small receive FIFO and sticky overrun / framing / parity flags.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | counting to the start-bit centre, rejecting glitches
// DATA   | sampling 8 data bits LSB first
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | sampling the stop bit, pushing or flagging the byte
module darkuart_rx #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 4,
    parameter int LW         = 3
) (
    input  logic            XCLK,
    input  logic            XRES,
    input  logic            UART_RXD,
    darkuart_rx_if.slave    bus
);
    localparam int DW = $clog2(BAUD_DIV);
    localparam int AW = LW - 1;
    localparam logic [DW-1:0] DIV_FULL = DW'(BAUD_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef DARKUART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div, div_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          rx_meta, rxs, rxs_q;
    logic          start_det, push, ferr_set, perr_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [LW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, do_pop, do_push, ovr_set;
    logic          ovr, ferr, perr;

    // Two-flop synchroniser plus an edge flop; reset to the idle-high level.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            rx_meta <= UART_RXD;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
        end
    end

    assign start_det = !rxs && rxs_q;

    // Receiver state and bit-timing registers.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            state   <= IDLE;
            div     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            div     <= div_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
        end
    end

    // Next-state, bit timing and per-frame push/error decisions.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        push      = 1'b0;
        ferr_set  = 1'b0;
        perr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start_det) begin
                    div_nxt   = DIV_HALF;
                    state_nxt = START;
                end
            end
            START: begin
                if (div == '0) begin
                    if (!rxs) begin
                        div_nxt   = DIV_FULL;
                        bit_nxt   = 3'd0;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    div_nxt = div - 1'b1;
                end
            end
            DATA: begin
                if (div == '0) begin
                    shift_nxt = {rxs, shift[7:1]};
                    div_nxt   = DIV_FULL;
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef DARKUART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    div_nxt = div - 1'b1;
                end
            end
`ifdef DARKUART_RX_PARITY_EN
            PARITY: begin
                if (div == '0) begin
                    perr_set  = (^shift) ^ rxs;
                    div_nxt   = DIV_FULL;
                    state_nxt = STOP;
                end else begin
                    div_nxt = div - 1'b1;
                end
            end
`endif
            STOP: begin
                if (div == '0) begin
                    if (rxs) push = 1'b1;
                    else     ferr_set = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = div - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pop on an empty FIFO is ignored; a push into a full FIFO only
    // succeeds when a pop frees the head slot in the same cycle.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = bus.RX_RD && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !do_pop;

    // FIFO pointers.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written, RX_DATA is gated.
    always_ff @(posedge XCLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= shift;
    end

    // Sticky status flags; a set in the same cycle as RX_CLR wins.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
            perr <= 1'b0;
        end else begin
            ovr  <= ovr_set  | (ovr  & !bus.RX_CLR);
            ferr <= ferr_set | (ferr & !bus.RX_CLR);
            perr <= perr_set | (perr & !bus.RX_CLR);
        end
    end

    assign bus.RX_DATA  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign bus.RX_VALID = !empty;
    assign bus.RX_LEVEL = wr_ptr - rd_ptr;
    assign bus.RX_OVR   = ovr;
    assign bus.RX_FERR  = ferr;
`ifdef DARKUART_RX_PARITY_EN
    assign bus.RX_PERR  = perr;
`else
    logic unused_perr;
    assign unused_perr = perr;
`endif
endmodule

// File: tb/tb_darkuart_rx.sv
// tb_darkuart_rx: directed bench for darkuart_rx (BAUD_DIV=16, FIFO_DEPTH=4).
// Bytes expected to land in the FIFO are queued when their frame is sent and
// compared against RX_DATA as they are popped.
module tb_darkuart_rx;
    localparam int BAUD = 16;
`ifdef DARKUART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // pin edge -> 2 sync stages + edge flop, half bit to start centre, then
    // NB-1 full bits to the stop-bit sample edge
    localparam int LAT = 3 + BAUD / 2 + (NB - 1) * BAUD;

    logic XCLK = 1'b0;
    logic XRES;
    logic UART_RXD;
    int   n_asserts = 0;
    int   n_fail = 0;
    logic [7:0] exp_q [$];

    darkuart_rx_if #(.LW(3)) bus ();

    darkuart_rx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(4), .LW(3)) dut (
        .XCLK     (XCLK),
        .XRES     (XRES),
        .UART_RXD (UART_RXD),
        .bus      (bus)
    );

    always #5 XCLK = ~XCLK;

    task automatic tick();
        @(posedge XCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, 32'(bus.RX_VALID), 32'd1);
        if (exp_q.size() == 0) begin
            n_asserts++;
            n_fail++;
            $display("FAIL %s: observed %0h expected nothing queued", tag, bus.RX_DATA);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(bus.RX_DATA), 32'(e));
        end
    endtask

    task automatic pop(input string tag);
        check_head(tag);
        bus.RX_RD = 1'b1;
        tick();
        bus.RX_RD = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.RX_CLR = 1'b1;
        tick();
        bus.RX_CLR = 1'b0;
        tick();
    endtask

    // Drives one frame; optional latency check and optional RX_RD timed so it
    // is sampled on edge rd_at (counted from the start-bit edge).
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input logic flip_par, input logic chk_lat,
                              input int rd_at, input int stop_after);
        logic [10:0] fr;
`ifdef DARKUART_RX_PARITY_EN
        fr = {stop_val, (^d) ^ flip_par, d, 1'b0};
`else
        fr = {1'b0, stop_val, d, 1'b0};
`endif
        for (int c = 0; c < NB * BAUD; c++) begin
            if (stop_after != 0 && c == stop_after) return;
            UART_RXD = fr[c / BAUD];
            if (rd_at != 0 && c == rd_at - 1) begin
                check_head("rd_collide");
                bus.RX_RD = 1'b1;
            end
            tick();
            bus.RX_RD = 1'b0;
            if (chk_lat && c + 1 == LAT - 1) check("lat_before", 32'(bus.RX_VALID), 32'd0);
            if (chk_lat && c + 1 == LAT)     check("lat_at",     32'(bus.RX_VALID), 32'd1);
        end
        UART_RXD = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic send(input logic [7:0] d, input logic expect_push);
        if (expect_push) exp_q.push_back(d);
        send_frame(d, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        XRES       = 1'b1;
        UART_RXD   = 1'b1;
        bus.RX_RD  = 1'b0;
        bus.RX_CLR = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("rst_valid", 32'(bus.RX_VALID), 32'd0);
        check("rst_level", 32'(bus.RX_LEVEL), 32'd0);
        check("rst_data",  32'(bus.RX_DATA),  32'd0);
        check("rst_ovr",   32'(bus.RX_OVR),   32'd0);
        check("rst_ferr",  32'(bus.RX_FERR),  32'd0);
        XRES = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // single byte with exact push latency
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 1'b1, 0, 0);
        check("one_level", 32'(bus.RX_LEVEL), 32'd1);
        pop("one_pop");
        check("one_empty", 32'(bus.RX_VALID), 32'd0);
        check("one_level0", 32'(bus.RX_LEVEL), 32'd0);

        // overrun: fifth byte dropped
        send(8'hA3, 1'b1);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h7E, 1'b1);
        check("full_ovr0", 32'(bus.RX_OVR), 32'd0);
        send(8'h11, 1'b0);
        check("ovr_level", 32'(bus.RX_LEVEL), 32'd4);
        check("ovr_flag",  32'(bus.RX_OVR),   32'd1);
        for (int i = 0; i < 4; i++) pop("ovr_pop");
        check("ovr_empty", 32'(bus.RX_VALID), 32'd0);
        bus.RX_RD = 1'b1;
        tick();
        bus.RX_RD = 1'b0;
        check("rd_empty_level", 32'(bus.RX_LEVEL), 32'd0);
        pulse_clr();
        check("ovr_clr", 32'(bus.RX_OVR), 32'd0);

        // framing error
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, 0);
        check("ferr_flag",  32'(bus.RX_FERR),  32'd1);
        check("ferr_level", 32'(bus.RX_LEVEL), 32'd0);
        pulse_clr();
        check("ferr_clr", 32'(bus.RX_FERR), 32'd0);

        // short glitch rejected
        UART_RXD = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        UART_RXD = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("glitch_level", 32'(bus.RX_LEVEL), 32'd0);
        check("glitch_ferr",  32'(bus.RX_FERR),  32'd0);
        check("glitch_ovr",   32'(bus.RX_OVR),   32'd0);
        send(8'h81, 1'b1);
        pop("glitch_next");

        // full FIFO, push and pop on the same edge
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        send(8'h04, 1'b1);
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, 1'b0, 1'b0, LAT, 0);
        check("coll_ovr",   32'(bus.RX_OVR),   32'd0);
        check("coll_level", 32'(bus.RX_LEVEL), 32'd4);
        for (int i = 0; i < 4; i++) pop("coll_pop");
        check("coll_empty", 32'(bus.RX_VALID), 32'd0);

        // reset mid-frame with stale byte and flag present
        send(8'h5A, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, 0);
        send_frame(8'hE7, 1'b1, 1'b0, 1'b0, 0, 4 * BAUD + BAUD / 2);
        XRES = 1'b1;
        tick();
        UART_RXD = 1'b1;
        tick();
        check("mrst_valid", 32'(bus.RX_VALID), 32'd0);
        check("mrst_level", 32'(bus.RX_LEVEL), 32'd0);
        check("mrst_data",  32'(bus.RX_DATA),  32'd0);
        check("mrst_ovr",   32'(bus.RX_OVR),   32'd0);
        check("mrst_ferr",  32'(bus.RX_FERR),  32'd0);
        XRES = 1'b0;
        for (int i = 0; i < 3 * BAUD; i++) tick();
        check("mrst_nopush", 32'(bus.RX_LEVEL), 32'd0);
        send(8'h42, 1'b1);
        check("post_rst_level", 32'(bus.RX_LEVEL), 32'd1);
        pop("post_rst");
`ifdef DARKUART_RX_PARITY_EN
        check("par_ok", 32'(bus.RX_PERR), 32'd0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 1'b1, 1'b0, 0, 0);
        check("par_err",   32'(bus.RX_PERR),  32'd1);
        check("par_level", 32'(bus.RX_LEVEL), 32'd1);
        pop("par_pop");
        pulse_clr();
        check("par_clr", 32'(bus.RX_PERR), 32'd0);
`endif
        check("final_ferr", 32'(bus.RX_FERR), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
